// File: rtl/regread_port_arbiter.sv
// rtl/regread_port_arbiter.sv - round-robin arbiter sharing one register-file read port
// Optional zero-register bypass enabled by defining REGREAD_XZR_EN.
module regread_port_arbiter #(
  parameter int NREQ  = 4,
  parameter int DATAW = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*5-1:0]  addr,
  output logic [4:0]         port_sel,
  input  logic [DATAW-1:0]   port_rdata,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    ack,
  output logic [DATAW-1:0]   rdata,
  output logic               busy
);

  localparam int PW = $clog2(NREQ);
  localparam logic [PW:0]   NREQ_P = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST   = PW'(NREQ - 1);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   nptr;
  logic [PW:0]     idx;
  logic            found;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnext;
  logic [4:0]      addr_arr [NREQ];
  logic [4:0]      win_addr;
  logic            win_xzr;
  logic            gnt_xzr;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i] = addr[i*5 +: 5];
    end
  end

  // A requester already holding the port or just acked has not yet dropped req.
  assign elig = req & ~grant & ~ack;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= NREQ_P) begin
        idx = idx - NREQ_P;
      end
      if (!found && elig[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    gnext      = '0;
    gnext[win] = 1'b1;
  end

  assign win_addr = addr_arr[win];
  assign nptr     = (win == LAST) ? '0 : win + 1'b1;

`ifdef REGREAD_XZR_EN
  assign win_xzr = (win_addr == 5'd31);
`else
  assign win_xzr = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant    <= '0;
      ack      <= '0;
      rdata    <= '0;
      port_sel <= '0;
      ptr      <= '0;
      gnt_xzr  <= 1'b0;
    end else begin
      ack <= grant;
      if (|grant) begin
        rdata <= gnt_xzr ? '0 : port_rdata;
      end
      if (!stall && found) begin
        grant   <= gnext;
        ptr     <= nptr;
        gnt_xzr <= win_xzr;
        // Zero-register reads leave the mux select where it was.
        if (!win_xzr) begin
          port_sel <= win_addr;
        end
      end else begin
        grant   <= '0;
        gnt_xzr <= 1'b0;
      end
    end
  end

  assign busy = (|grant) | (|ack);

endmodule

// File: tb/tb_regread_port_arbiter.sv
// tb/tb_regread_port_arbiter.sv - self-checking bench for regread_port_arbiter
// Honours REGREAD_XZR_EN to select the zero-register expectation.
module tb_regread_port_arbiter;

  localparam int NREQ  = 4;
  localparam int DATAW = 64;
`ifdef REGREAD_XZR_EN
  localparam bit XZR_EN = 1'b1;
`else
  localparam bit XZR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              stall;
  logic [NREQ-1:0]   req;
  logic [NREQ*5-1:0] addr;
  logic [4:0]        port_sel;
  logic [DATAW-1:0]  port_rdata;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ack;
  logic [DATAW-1:0]  rdata;
  logic              busy;

  logic [63:0] bank [32];
  assign port_rdata = bank[port_sel];

  always #5 clk = ~clk;

  regread_port_arbiter #(.NREQ(NREQ), .DATAW(DATAW)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .req(req), .addr(addr),
    .port_sel(port_sel), .port_rdata(port_rdata), .grant(grant), .ack(ack),
    .rdata(rdata), .busy(busy)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit auto_req = 1'b0;

  // Reference state: indices of granted/acked requesters (-1 = none).
  int          m_gnt, m_ack, m_ptr;
  logic [4:0]  m_sel, m_gaddr;
  logic [63:0] m_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] onehot(input int i);
    logic [63:0] v;
    v = 64'd0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_gnt = -1; m_ack = -1; m_ptr = 0;
    m_sel = 5'd0; m_gaddr = 5'd0; m_rdata = 64'd0;
  endtask

  task automatic step();
    int ng, na, np;
    logic [4:0]  ns, nga;
    logic [63:0] nr;
    na = m_gnt; nr = m_rdata; ng = -1; np = m_ptr; ns = m_sel; nga = m_gaddr;
    if (m_gnt >= 0) nr = (XZR_EN && m_gaddr == 5'd31) ? 64'd0 : bank[m_gaddr];
    if (!stall) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (ng < 0 && req[i] && i != m_gnt && i != m_ack) ng = i;
      end
    end
    if (ng >= 0) begin
      np  = (ng + 1) % NREQ;
      nga = addr[ng*5 +: 5];
      if (!(XZR_EN && nga == 5'd31)) ns = nga;
    end
    @(posedge clk);
    #1;
    m_gnt = ng; m_ack = na; m_ptr = np; m_sel = ns; m_gaddr = nga; m_rdata = nr;
    check("grant", 64'(grant), onehot(m_gnt));
    check("ack", 64'(ack), onehot(m_ack));
    check("port_sel", 64'(port_sel), 64'(m_sel));
    check("busy", 64'(busy), 64'(m_gnt >= 0 || m_ack >= 0));
    if (m_ack >= 0) check("rdata", rdata, m_rdata);
    for (int i = 0; i < NREQ; i++) begin
      if (m_ack == i) req[i] = 1'b0;
      else if (auto_req && !req[i] && $urandom_range(0, 2) == 0) begin
        addr[i*5 +: 5] = 5'($urandom_range(0, 31));
        req[i] = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [4:0] sel_before;

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = {$urandom, $urandom};
    bank[7]  = 64'hDEAD_BEEF;
    bank[31] = 64'hFFFF_FFFF_FFFF_FFFF;
    req = '0; addr = '0; stall = 1'b0;

    // Reset values
    do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_port_sel", 64'(port_sel), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;

    // Single read from requester 1, register 7
    addr[9:5] = 5'd7; req = 4'b0010;
    step();
    check("single_sel", 64'(port_sel), 64'd7);
    step();
    check("single_ack", 64'(ack), 64'b0010);
    check("single_rdata", rdata, 64'hDEAD_BEEF);
    step();
    check("single_one_pulse", 64'(ack), 64'd0);

    // Contention from pointer 0
    do_reset();
    for (int i = 0; i < NREQ; i++) addr[i*5 +: 5] = 5'(i + 3);
    req = 4'b1111;
    step();
    for (int i = 0; i < NREQ; i++) begin
      step();
      check("contention_ack", 64'(ack), onehot(i));
    end
    step();
    check("contention_idle", 64'(grant), 64'd0);

    // Wrap: grant to 2, then 0 wins over 2 via 3 -> 0
    req = 4'b0100;
    step();
    check("wrap_g2", 64'(grant), 64'b0100);
    req = 4'b0101;
    step();
    check("wrap_g0", 64'(grant), 64'b0001);
    step(); step();

    // Stall after grant to requester 0
    do_reset();
    addr[4:0] = 5'd10; addr[9:5] = 5'd11;
    req = 4'b0011;
    step();
    check("stall_g0", 64'(grant), 64'b0001);
    stall = 1'b1;
    step();
    check("stall_ack0", 64'(ack), 64'b0001);
    check("stall_nogrant", 64'(grant), 64'd0);
    step();
    check("stall_hold", 64'(grant), 64'd0);
    stall = 1'b0;
    step();
    check("stall_g1", 64'(grant), 64'b0010);
    step();
    check("stall_ack1", 64'(ack), 64'b0010);
    step();

    // Zero-register read from requester 3
    sel_before = port_sel;
    addr[19:15] = 5'd31; req = 4'b1000;
    step();
    check("xzr_sel", 64'(port_sel), XZR_EN ? 64'(sel_before) : 64'd31);
    step();
    check("xzr_ack", 64'(ack), 64'b1000);
    check("xzr_rdata", rdata, XZR_EN ? 64'd0 : 64'hFFFF_FFFF_FFFF_FFFF);
    step();

    // Async reset mid-grant, then requester 0 still held
    addr[4:0] = 5'd5; req = 4'b0001;
    step();
    check("midrst_grant_pre", 64'(grant), 64'b0001);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst_grant", 64'(grant), 64'd0);
    check("midrst_ack", 64'(ack), 64'd0);
    check("midrst_rdata", rdata, 64'd0);
    #2;
    reset_n = 1'b1;
    step();
    step();
    check("midrst_ack0", 64'(ack), 64'b0001);
    step();

    // Randomized traffic with random stalls
    auto_req = 1'b1;
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      step();
    end
    auto_req = 1'b0;
    stall = 1'b0;
    repeat (NREQ * 3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
